// File: rtl/riscv_dec_stage.sv
// rtl/riscv_dec_stage.sv - RISC-V base-instruction decode stage with two-entry skid buffer
//
// Purpose: classifies a raw 32-bit instruction, extracts rd/rs1/rs2 and the
// sign-extended immediate, flags and counts illegal encodings, and registers
// the result behind a main register plus one skid register.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_vld/in_rdy      instruction handshake (in_rdy is registered, = !skid full)
//   in_ins             raw instruction
//   out_vld/out_rdy    decoded entry handshake
//   out_fmt            0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
//   out_rd/rs1/rs2     register indices (0 when the format has no such field)
//   out_imm            immediate sign-extended to XLEN
//   out_ill            illegal instruction
//   ill_cnt            saturating count of accepted illegal instructions
module riscv_dec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      in_ins,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [2:0]       out_fmt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_ill,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            ill;
  } entry_t;

  // An empty/illegal-looking slot: format "none", everything else zero.
  localparam entry_t ENTRY_RST = {FMT_X, {(15 + XLEN + 1){1'b0}}};

  entry_t      dec;
  logic [2:0]  fmt;
  logic [31:0] imm32;

  entry_t main_q;
  entry_t skid_q;
  logic   main_vld;
  logic   skid_vld;
  logic   in_xfer;
  logic   out_xfer;

  // Combinational decode of the instruction currently offered.
  always_comb begin
    fmt = FMT_X;
    if (in_ins[1:0] == 2'b11) begin
      case (in_ins[6:2])
        5'b01101, 5'b00101:                            fmt = FMT_U;
        5'b11011:                                      fmt = FMT_J;
        5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: fmt = FMT_I;
        5'b11000:                                      fmt = FMT_B;
        5'b01000:                                      fmt = FMT_S;
        5'b01100:                                      fmt = FMT_R;
        5'b00110: if (XLEN == 64)                      fmt = FMT_I;
        5'b01110: if (XLEN == 64)                      fmt = FMT_R;
        default:                                       fmt = FMT_X;
      endcase
    end

    case (fmt)
      FMT_I:   imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
      FMT_S:   imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      FMT_B:   imm32 = {{20{in_ins[31]}}, in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
      FMT_U:   imm32 = {in_ins[31:12], 12'h000};
      FMT_J:   imm32 = {{12{in_ins[31]}}, in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase

    dec          = ENTRY_RST;
    dec.fmt      = fmt;
    dec.ill      = (fmt == FMT_X);
    // Fill with the sign bit first so widths above 32 are extended.
    dec.imm      = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.rd       = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? in_ins[11:7]  : 5'd0;
    dec.rs1      = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) ? in_ins[19:15] : 5'd0;
    dec.rs2      = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B)                 ? in_ins[24:20] : 5'd0;
  end

  assign in_rdy   = !skid_vld;
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = main_vld && out_rdy;

  // Main/skid storage. A full skid implies a full main and in_rdy=0, so no
  // input can arrive while the skid is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= ENTRY_RST;
      skid_q   <= ENTRY_RST;
    end else if (skid_vld) begin
      if (out_xfer) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (!main_vld || out_xfer) begin
      // Main is free this cycle: new entry goes straight in, else main empties.
      main_vld <= in_xfer;
      if (in_xfer) begin
        main_q <= dec;
      end
    end else if (in_xfer) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_cnt <= '0;
    end else if (in_xfer && dec.ill && (ill_cnt != {CNT_W{1'b1}})) begin
      ill_cnt <= ill_cnt + CNT_W'(1);
    end
  end

  assign out_vld = main_vld;
  assign out_fmt = main_q.fmt;
  assign out_rd  = main_q.rd;
  assign out_rs1 = main_q.rs1;
  assign out_rs2 = main_q.rs2;
  assign out_imm = main_q.imm;
  assign out_ill = main_q.ill;

endmodule

// File: tb/tb_riscv_dec_stage.sv
// tb/tb_riscv_dec_stage.sv - scoreboard bench for riscv_dec_stage
module tb_riscv_dec_stage;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] in_ins;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_ill;
  logic [15:0] ill_cnt;

  logic        v64, r64, o64_vld, o64_ill, rdy64;
  logic [31:0] i64;
  logic [2:0]  o64_fmt;
  logic [4:0]  o64_rd, o64_rs1, o64_rs2;
  logic [63:0] o64_imm;
  logic [15:0] cnt64;

  logic        vc, rc, oc_vld, oc_ill, rdyc;
  logic [31:0] ic;
  logic [2:0]  oc_fmt;
  logic [4:0]  oc_rd, oc_rs1, oc_rs2;
  logic [31:0] oc_imm;
  logic [1:0]  cntc;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   pop_cyc[$];

  riscv_dec_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_ins(in_ins),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_fmt(out_fmt), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_ill(out_ill),
    .ill_cnt(ill_cnt));

  riscv_dec_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .in_vld(v64), .in_rdy(rdy64), .in_ins(i64),
    .out_vld(o64_vld), .out_rdy(r64), .out_fmt(o64_fmt), .out_rd(o64_rd),
    .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_imm(o64_imm), .out_ill(o64_ill),
    .ill_cnt(cnt64));

  riscv_dec_stage #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .rst(rst), .in_vld(vc), .in_rdy(rdyc), .in_ins(ic),
    .out_vld(oc_vld), .out_rdy(rc), .out_fmt(oc_fmt), .out_rd(oc_rd),
    .out_rs1(oc_rs1), .out_rs2(oc_rs2), .out_imm(oc_imm), .out_ill(oc_ill),
    .ill_cnt(cntc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] f, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] imm, input logic ill);
    return {f, rd, rs1, rs2, imm, ill};
  endfunction

  localparam exp_t E_ILL = {3'd7, 15'd0, 32'd0, 1'b1};

  // Monitor: an entry is consumed at the next edge when out_vld&out_rdy here.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (!rst && out_vld && out_rdy) begin
      got = {out_fmt, out_rd, out_rs1, out_rs2, out_imm, out_ill};
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got fmt=%0d imm=%h", out_fmt, out_imm);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL entry got fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b expected fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b",
                   got.fmt, got.rd, got.rs1, got.rs2, got.imm, got.ill,
                   e.fmt, e.rd, e.rs1, e.rs2, e.imm, e.ill);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] ins, input exp_t e);
    int waitc = 0;
    in_vld = 1'b1;
    in_ins = ins;
    while (!in_rdy && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_rdy) begin
      chk("send_timeout", 64'(in_rdy), 64'd1);
      in_vld = 1'b0;
      return;
    end
    sbq.push_back(e);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #2 out_rdy = v;
  endtask

  initial begin
    int t0;
    rst = 1'b1; in_vld = 1'b0; in_ins = '0; out_rdy = 1'b1;
    v64 = 1'b0; i64 = '0; r64 = 1'b1;
    vc = 1'b0; ic = '0; rc = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_fmt", 64'(out_fmt), 64'd7);
    chk("rst_fields", {out_rd, out_rs1, out_rs2, out_ill}, 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_ill_cnt", 64'(ill_cnt), 64'd0);

    // addi x1,x2,-1 with one-cycle latency
    send(32'hFFF10093, mk(3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0));
    #1 chk("latency_1", 64'(sbq.size()), 64'd0);

    // back-to-back: sw, beq, lui, jal
    @(negedge clk);
    t0 = cyc;
    send(32'h00552423, mk(3'd2, 5'd0, 5'd10, 5'd5, 32'h00000008, 1'b0));
    send(32'hFE000EE3, mk(3'd3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
    send(32'h123451B7, mk(3'd4, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0));
    send(32'h008000EF, mk(3'd5, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0));
    chk("b2b_accept_cycles", 64'(cyc - t0), 64'd4);
    #1 chk("b2b_drained", 64'(sbq.size()), 64'd0);
    chk("b2b_out_rate", 64'(pop_cyc[$] - pop_cyc[$-3]), 64'd3);

    // illegal encodings, then addw which is illegal at XLEN=32
    @(negedge clk);
    send(32'h0000007F, E_ILL);
    send(32'h00000000, E_ILL);
    #1 chk("ill_cnt_2", 64'(ill_cnt), 64'd2);
    @(negedge clk);
    send(32'h003100BB, E_ILL);
    #1 chk("ill_cnt_addw32", 64'(ill_cnt), 64'd3);

    // backpressure: two accepted, third held until out_rdy rises
    set_rdy(1'b0);
    @(negedge clk);
    send(32'hFFF10093, mk(3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0));
    send(32'h00552423, mk(3'd2, 5'd0, 5'd10, 5'd5, 32'h00000008, 1'b0));
    chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
    in_vld = 1'b1;
    in_ins = 32'h123451B7;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_in_rdy", 64'(in_rdy), 64'd0);
      chk("bp_hold_out", {out_vld, out_fmt, out_rd, out_imm}, {1'b1, 3'd1, 5'd1, 32'hFFFFFFFF});
    end
    set_rdy(1'b1);
    send(32'h123451B7, mk(3'd4, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0));
    @(negedge clk);
    #1 chk("bp_drained", 64'(sbq.size()), 64'd0);
    chk("bp_out_rate", 64'(pop_cyc[$] - pop_cyc[$-2]), 64'd2);

    // reset with both entries full
    set_rdy(1'b0);
    @(negedge clk);
    send(32'h0000007F, E_ILL);
    send(32'hFE000EE3, mk(3'd3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
    chk("pre_rst_full", {in_rdy, out_vld}, {1'b0, 1'b1});
    @(posedge clk);
    #2 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_out_vld", 64'(out_vld), 64'd0);
    chk("midrst_in_rdy", 64'(in_rdy), 64'd1);
    chk("midrst_ill_cnt", 64'(ill_cnt), 64'd0);
    chk("midrst_out_fmt", 64'(out_fmt), 64'd7);
    send(32'h003100BB, E_ILL);
    #1 chk("post_rst_drained", 64'(sbq.size()), 64'd0);

    // XLEN=64 instance
    @(negedge clk);
    v64 = 1'b1; i64 = 32'h003100BB;
    @(negedge clk);
    v64 = 1'b0;
    chk("x64_addw", {o64_vld, o64_fmt, o64_rd, o64_rs1, o64_rs2, o64_ill},
        {1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0});
    chk("x64_addw_imm", o64_imm, 64'd0);
    v64 = 1'b1; i64 = 32'hFFF10093;
    @(negedge clk);
    v64 = 1'b0;
    chk("x64_addi_imm", o64_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("x64_addi_fmt", {o64_vld, o64_fmt, o64_ill}, {1'b1, 3'd1, 1'b0});

    // CNT_W=2 saturation
    vc = 1'b1; ic = 32'h0000007F;
    repeat (6) @(negedge clk);
    vc = 1'b0;
    chk("cnt2_saturate", 64'(cntc), 64'd3);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_dec_stage.md
# riscv_dec_stage

Registered, parametrised RISC-V base-instruction decode stage. It takes a raw 32-bit instruction over a valid/ready handshake and classifies its format. It extracts register indices and the fully sign-extended XLEN-wide immediate, flags illegal encodings and counts them. It sits between instruction fetch and the register-file read/execute stage, with a two-entry skid buffer so that full throughput is kept under backpressure.

## Interface
- XLEN, default 32: datapath width, 32 or 64; 64 additionally enables OP-IMM-32 and OP-32.
- CNT_W, default 16: width of the illegal-instruction counter.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_vld  in  1  instruction valid
- in_rdy  out  1  stage can accept an instruction
- in_ins  in  32  raw instruction
- out_vld  out  1  decoded entry valid
- out_rdy  in  1  consumer accepts the entry
- out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 none (illegal)
- out_rd  out  5  destination register
- out_rs1  out  5  source register 1
- out_rs2  out  5  source register 2
- out_imm  out  XLEN  sign-extended immediate
- out_ill  out  1  illegal instruction
- ill_cnt  out  CNT_W  saturating count of illegal instructions accepted

## Operation
- Input transfer happens when in_vld&in_rdy; output transfer happens when out_vld&out_rdy.
- Decoding is combinational on in_ins and is captured into the stage on input transfer.
- Opcode map, using ins[6:2] with ins[1:0]==2'b11:
  - LUI 01101, AUIPC 00101: U
  - JAL 11011: J
  - JALR 11001, LOAD 00000, OP-IMM 00100, MISC-MEM 00011, SYSTEM 11100: I
  - BRANCH 11000: B
  - STORE 01000: S
  - OP 01100: R
  - XLEN==64 only: OP-IMM-32 00110 is I, OP-32 01110 is R
  - Anything else, or ins[1:0]!=2'b11, is illegal.
- Field rules:
  - rd = ins[11:7] for R/I/U/J, else 0.
  - rs1 = ins[19:15] for R/I/S/B, else 0.
  - rs2 = ins[24:20] for R/S/B, else 0.
- Immediate, sign-extended from ins[31] to XLEN:
  - I: ins[31:20]
  - S: {ins[31:25],ins[11:7]}
  - B: {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}
  - U: {ins[31:12],12'h0}
  - J: {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}
  - R: 0
- Illegal entry: fmt=7, ill=1, rd/rs1/rs2/imm=0. The entry still flows through the pipeline in order.
- ill_cnt increments by 1 on each input transfer of an illegal instruction and saturates at 2^CNT_W-1.
- Storage is a main register (drives out_*) plus one skid register.
  - Empty: an accepted instruction goes to main.
  - Main full with out_rdy=0: an accepted instruction goes to skid.
  - Output transfer with skid full: skid moves to main in the same cycle.
- in_rdy is a register and equals !skid_full.
- Order is strictly FIFO. No entry is lost or duplicated.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is on out_* with out_vld=1 after edge N, if main was empty or transferring.
- Throughput: 1 instruction per cycle while out_rdy=1.
- in_rdy falls the cycle after skid becomes full. It rises the cycle after the skid drains.
- Simultaneous input and output transfer with main full and skid empty: the new entry replaces main directly; skid stays empty.
- out_* are stable while out_vld=1 and out_rdy=0.
- Reset values: out_vld=0, in_rdy=1, out_fmt=7, out_rd/rs1/rs2=0, out_imm=0, out_ill=0, ill_cnt=0.
- Reset mid-operation: both entries are discarded and no output transfer occurs in the reset cycle.

## Test plan
- addi x1,x2,-1 (0xFFF10093), XLEN=32 -> next cycle out_vld=1, fmt=1, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, ill=0.
- Back-to-back with out_rdy=1:
  - sw x5,8(x10) (0x00552423) -> fmt=2, rd=0, rs1=10, rs2=5, imm=8.
  - beq x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC.
  - lui x3,0x12345 (0x123451B7) -> fmt=4, rd=3, imm=0x12345000.
  - One result per cycle.
- Illegal inputs 0x0000007F and 0x00000000 -> fmt=7, ill=1, all fields 0, ill_cnt=2. With CNT_W=2, six illegal inputs -> ill_cnt=3.
- Backpressure: out_rdy=0, offer 3 instructions -> 2 accepted, in_rdy=0, third held. Raise out_rdy -> all 3 emerge in order, 1 per cycle.
- XLEN=64:
  - OP-32 addw (0x003100BB) -> fmt=0, legal.
  - addi -1 -> imm=0xFFFFFFFFFFFFFFFF.
  - With XLEN=32 the same addw -> ill=1.
- Assert rst with both entries full -> next cycle out_vld=0, in_rdy=1, ill_cnt=0.
